// File: rtl/alu_multiciclo.sv
// alu_multiciclo: execution-stage ALU. Logic/add/sub finish in one cycle;
// signed mult/div iterate WIDTH steps (ITER) then a sign fix-up (FIX) and
// update HI/LO. Optional divider is enabled by defining ALU_DIV_EN; without
// it code 0100 is reported as illegal and no divider logic is built.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             ovf,
  output logic             div_zero,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MULT = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_JR   = 4'b1011;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'b0100;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  // acc: mult -> {partial hi, multiplier/low product}; div -> {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
`ifdef ALU_DIV_EN
  logic               is_div_q, is_div_d;
  logic               neg_rem_q, neg_rem_d;
`endif
  logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
  logic               ill_q, ill_d, done_q, done_d;

  logic               is_mult, launch;
  logic [WIDTH-1:0]   abs_a, abs_b, add_r, sub_r;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;

  assign is_mult  = (ALU_FUN == OP_MULT);
  assign abs_a    = a[WIDTH-1] ? -a : a;
  assign abs_b    = b[WIDTH-1] ? -b : b;
  assign add_r    = a + b;
  assign sub_r    = a - b;

  // One shift-add step: add multiplicand when LSB set, then shift right with carry.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef ALU_DIV_EN
  logic             is_div_op, b_zero;
  logic [WIDTH:0]   r_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_div_op = (ALU_FUN == OP_DIV);
  assign b_zero    = (b == {WIDTH{1'b0}});
  assign launch    = start & (is_mult | (is_div_op & ~b_zero));
  // Restoring step: shift next dividend bit into remainder, keep the difference if non-negative.
  assign r_sh      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = r_sh - {1'b0, opnd_q};
  assign div_next  = div_diff[WIDTH] ? {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
  assign launch    = start & is_mult;
`endif

  // Single-cycle result and flags for the current code.
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf, sc_ill;
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (ALU_FUN)
      OP_ADD: begin
        sc_res = add_r;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_r;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOR:  sc_res = ~(a | b);
      OP_XOR:  sc_res = a ^ b;
      OP_NOT:  sc_res = ~a;
      OP_NAND: sc_res = ~(a & b);
      OP_JR:   sc_res = a;
      default: sc_ill = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: long ops walk IDLE -> ITER (WIDTH steps) -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = ITER;
      ITER:    if (cnt_q == 6'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next-state: operand latch, iteration step, result/flag writeback.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
`ifdef ALU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mult) begin
            cnt_d  = '0;
            opnd_d = abs_a;
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_DIV_EN
            is_div_d = 1'b0;
          end else if (is_div_op && !b_zero) begin
            cnt_d     = '0;
            opnd_d    = abs_b;
            acc_d     = {{WIDTH{1'b0}}, abs_a};
            neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            is_div_d  = 1'b1;
          end else if (is_div_op) begin
            // Divide by zero resolves immediately.
            lo_d     = '1;
            hi_d     = a;
            result_d = '1;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            dz_d     = 1'b1;
            ill_d    = 1'b0;
            done_d   = 1'b1;
`endif
          end else begin
            result_d = sc_res;
            zero_d   = (sc_res == '0);
            ovf_d    = sc_ovf;
            ill_d    = sc_ill;
            dz_d     = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q + 6'd1;
`ifdef ALU_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
      end
      FIX: begin
`ifdef ALU_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`else
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`endif
        result_d = lo_d;
        zero_d   = (lo_d == '0);
        ovf_d    = 1'b0;
        dz_d     = 1'b0;
        ill_d    = 1'b0;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any iteration and clears all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      ill_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
`ifdef ALU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
`endif
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      ill_q     <= ill_d;
      done_q    <= done_d;
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign zero     = zero_q;
  assign ovf      = ovf_q;
  assign div_zero = dz_q;
  assign illegal  = ill_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_alu_multiciclo;
  logic        clk, rst_n, start;
  logic [3:0]  ALU_FUN;
  logic [31:0] a, b, result, hi, lo;
  logic        zero, ovf, div_zero, illegal, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_hi = 0, m_lo = 0, m_res = 0;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  alu_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_FUN(ALU_FUN), .a(a), .b(b),
    .result(result), .hi(hi), .lo(lo), .zero(zero), .ovf(ovf),
    .div_zero(div_zero), .illegal(illegal), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: architectural result of one op from signed arithmetic.
  function automatic void model(input logic [3:0] f, input logic [31:0] x, y,
                                output logic [31:0] r, h, l,
                                output logic z, ov, dz, il, output int lat);
    longint sx, sy, s, rm;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s = 0; rm = 0;
    r = 0; h = m_hi; l = m_lo; ov = 0; dz = 0; il = 0; lat = 1;
    case (f)
      4'd1: begin s = sx + sy; r = s[31:0]; ov = (s > MAXI) || (s < MINI); end
      4'd2: begin s = sx - sy; r = s[31:0]; ov = (s > MAXI) || (s < MINI); end
      4'd3: begin s = sx * sy; h = s[63:32]; l = s[31:0]; r = l; lat = 34; end
      4'd4: begin
`ifdef ALU_DIV_EN
        if (y == 0) begin
          l = 32'hFFFF_FFFF; h = x; r = l; dz = 1;
        end else begin
          s = sx / sy; rm = sx % sy;
          l = s[31:0]; h = rm[31:0]; r = l; lat = 34;
        end
`else
        il = 1;
`endif
      end
      4'd5:  r = x & y;
      4'd6:  r = x | y;
      4'd7:  r = ~(x | y);
      4'd8:  r = x ^ y;
      4'd9:  r = ~x;
      4'd10: r = ~(x & y);
      4'd11: r = x;
      default: il = 1;
    endcase
    z = (r == 0);
  endfunction

  // Issue one op (caller sits at a negedge), wait for done, check everything.
  task automatic run_op(input logic [3:0] f, input logic [31:0] x, y, input bit poke);
    logic [31:0] er, eh, el;
    logic ez, eo, ed, ei;
    int elat, lat, nbusy;
    model(f, x, y, er, eh, el, ez, eo, ed, ei, elat);
    start = 1'b1; ALU_FUN = f; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ALU_FUN = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1; nbusy = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) nbusy++;
      if (poke && lat == 5) begin start = 1'b1; ALU_FUN = 4'b1000; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(elat));
    chk("busy_cycles", 32'(nbusy), 32'(elat - 1));
    chk1("busy_at_done", busy, 1'b0);
    chk("result", result, er);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk1("zero", zero, ez);
    chk1("ovf", ovf, eo);
    chk1("div_zero", div_zero, ed);
    chk1("illegal", illegal, ei);
    m_hi = eh; m_lo = el; m_res = er;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_hi"}, hi, 32'h0);
    chk({tag, "_lo"}, lo, 32'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [3:0]  f;
    rst_n = 1'b0; start = 1'b0; ALU_FUN = 4'd0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    chk_cleared("por");
    chk1("por_zero", zero, 1'b0);
    chk1("por_illegal", illegal, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a multiply.
    start = 1'b1; ALU_FUN = 4'd3; a = 32'hFFFF_FFFD; b = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk1("midmult_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_cleared("inrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_cleared("postrst");
    m_hi = 0; m_lo = 0;

    run_op(4'd1, 32'd3, 32'd4, 1'b0);
    run_op(4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(4'd2, 32'd5, 32'd5, 1'b0);
    // Mult with an ignored xor start mid-flight, then nor issued on E34.
    run_op(4'd3, 32'hFFFF_FFFD, 32'h4000_0000, 1'b1);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'h4000_0000);
    run_op(4'd7, 32'd0, 32'd0, 1'b0);
    chk("nor_const", result, 32'hFFFF_FFFF);
    run_op(4'd4, 32'h0000_0013, 32'd0, 1'b0);
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef ALU_DIV_EN
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd9, 32'd0, 1'b0);
    chk("div0_hi_const", hi, 32'd9);
`else
    chk("nodiv_hi_kept", hi, 32'hFFFF_FFFF);
    chk("nodiv_lo_kept", lo, 32'h4000_0000);
`endif
    run_op(4'd11, 32'h0040_0020, 32'h1234_5678, 1'b0);
    run_op(4'd15, 32'h1111_1111, 32'h2222_2222, 1'b0);
    run_op(4'd0, 32'h1111_1111, 32'h2222_2222, 1'b0);

    // Random ops with some corner-value operands.
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 3) == 0) x = (($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF);
      if ($urandom_range(0, 5) == 0) y = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(1, 30);
      run_op(f, x, y, 1'b0);
    end

    // Result and done hold while idle.
    repeat (3) begin
      @(negedge clk);
      chk1("idle_done", done, 1'b0);
      chk("idle_result", result, m_res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
